// File: rtl/pamac_vec_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pamac_pkg
//  Purpose  : Shared types and arithmetic helpers for the pamac_vec
//             term-serial multiply-accumulate engine.
//             - state_t   : engine FSM states
//             - etc_clamp : limit a term count to the supported maximum
//             - sat_add   : one add/sub step with optional signed saturation
//  Revision : 1.0  initial release
// ============================================================================
package pamac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Term counts above the supported maximum are treated as the maximum.
    function automatic logic [31:0] etc_clamp(input logic [31:0] etc,
                                              input logic [31:0] max_terms);
        return (etc > max_terms) ? max_terms : etc;
    endfunction

    // One accumulation step. acc and term arrive sign-extended to 64 bits
    // from a 'width'-bit signed value (width <= 63). The exact result is
    // formed in 65 bits so it can never overflow before clamping. The caller
    // keeps the low 'width' bits, which gives wrap-around when sat_en=0.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] acc,
                                                   input logic signed [63:0] term,
                                                   input logic               sub,
                                                   input logic               sat_en,
                                                   input int unsigned        width);
        logic signed [64:0] exact;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        if (sub) begin
            exact = {acc[63], acc} - {term[63], term};
        end else begin
            exact = {acc[63], acc} + {term[63], term};
        end
        hi = (65'sd1 <<< (width - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (width - 1));
        if (sat_en && (exact > hi)) begin
            exact = hi;
        end else if (sat_en && (exact < lo)) begin
            exact = lo;
        end
        return 64'(exact);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pamac_vec_if.sv
`default_nettype none
// ============================================================================
//  Module   : pamac_vec_if
//  Purpose  : Operand/result bus of the pamac_vec engine.
//             Input side : in_valid/in_ready handshake, per-lane activations
//                          (in_a), partial sums (in_t), term counts (in_etc),
//                          term positions (in_pos), term signs (in_neg),
//                          a_signed and sat_en mode bits.
//             Output side: out_valid/out_ready handshake, lane results
//                          (out_y), busy status.
//             master = producer/consumer side, slave = engine side.
//  Revision : 1.0  initial release
// ============================================================================
interface pamac_vec_if #(
    parameter int LANES     = 4,
    parameter int A_W       = 16,
    parameter int ACC_W     = 24,
    parameter int MAX_TERMS = 8,
    parameter int POS_W     = 4,
    parameter int ETC_W     = $clog2(MAX_TERMS + 1)
);
    logic                             in_valid;
    logic                             in_ready;
    logic [LANES*A_W-1:0]             in_a;
    logic [LANES*ACC_W-1:0]           in_t;
    logic [LANES*ETC_W-1:0]           in_etc;
    logic [LANES*MAX_TERMS*POS_W-1:0] in_pos;
    logic [LANES*MAX_TERMS-1:0]       in_neg;
    logic                             a_signed;
    logic                             sat_en;
    logic                             out_valid;
    logic                             out_ready;
    logic [LANES*ACC_W-1:0]           out_y;
    logic                             busy;

    modport master (
        output in_valid, in_a, in_t, in_etc, in_pos, in_neg, a_signed, sat_en,
               out_ready,
        input  in_ready, out_valid, out_y, busy
    );

    modport slave (
        input  in_valid, in_a, in_t, in_etc, in_pos, in_neg, a_signed, sat_en,
               out_ready,
        output in_ready, out_valid, out_y, busy
    );
endinterface
`default_nettype wire

// File: rtl/pamac_vec_term_lane.sv
`default_nettype none
// ============================================================================
//  Module   : pamac_term_lane
//  Purpose  : One lane of the term-serial MAC. Captures its operands on
//             'load', then on each 'step' cycle applies term k (if k is
//             below the lane's own term count) to the accumulator.
//  Ports    : clk, rst            clock / sync active-high reset
//             load                capture a, t, etc, pos, neg
//             step                engine is in RUN
//             k                   current term index
//             a, t, etc, pos, neg lane operands (etc already clamped)
//             a_signed, sat_en    captured mode bits from the engine
//             y                   accumulator value
//  Revision : 1.0  initial release
// ============================================================================
module pamac_term_lane
    import pamac_pkg::*;
#(
    parameter int A_W       = 16,
    parameter int ACC_W     = 24,
    parameter int MAX_TERMS = 8,
    parameter int POS_W     = 4,
    parameter int ETC_W     = 4
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         load,
    input  wire logic                         step,
    input  wire logic [ETC_W-1:0]             k,
    input  wire logic [A_W-1:0]               a,
    input  wire logic [ACC_W-1:0]             t,
    input  wire logic [ETC_W-1:0]             etc,
    input  wire logic [MAX_TERMS*POS_W-1:0]   pos,
    input  wire logic [MAX_TERMS-1:0]         neg,
    input  wire logic                         a_signed,
    input  wire logic                         sat_en,
    output logic      [ACC_W-1:0]             y
);

    logic [A_W-1:0]             r_a;
    logic [ACC_W-1:0]           r_acc;
    logic [ETC_W-1:0]           r_etc;
    logic [MAX_TERMS*POS_W-1:0] r_pos;
    logic [MAX_TERMS-1:0]       r_neg;

    logic [POS_W-1:0]           w_pos;
    logic                       w_neg;
    logic [ACC_W-1:0]           w_a_ext;
    logic [ACC_W-1:0]           w_term;
    logic [ACC_W-1:0]           w_next;

    // Term selection by the shared term index.
    always_comb begin
        w_pos = '0;
        w_neg = 1'b0;
        for (int j = 0; j < MAX_TERMS; j++) begin
            if (k == ETC_W'(j)) begin
                w_pos = r_pos[j*POS_W +: POS_W];
                w_neg = r_neg[j];
            end
        end
    end

    always_comb begin
        if (a_signed) begin
            w_a_ext = ACC_W'($signed(r_a));
        end else begin
            w_a_ext = ACC_W'(r_a);
        end
        // Shift is done at accumulator width, so high bits fall off here.
        w_term = w_a_ext << w_pos;
        w_next = ACC_W'(sat_add(64'($signed(r_acc)), 64'($signed(w_term)),
                                w_neg, sat_en, ACC_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_acc <= '0;
            r_etc <= '0;
            r_pos <= '0;
            r_neg <= '0;
        end else if (load) begin
            r_a   <= a;
            r_acc <= t;
            r_etc <= etc;
            r_pos <= pos;
            r_neg <= neg;
        end else if (step && (k < r_etc)) begin
            r_acc <= w_next;
        end
    end

    assign y = r_acc;

endmodule
`default_nettype wire

// File: rtl/pamac_vec.sv
`default_nettype none
// ============================================================================
//  Module   : pamac_vec
//  Purpose  : Multi-lane term-serial multiply-accumulate engine. Each lane
//             adds A * sum(+/-2^pos_k) to a partial sum, one term per cycle;
//             the run ends after the longest lane's term count.
//  Ports    : clk   clock
//             rst   synchronous active-high reset
//             bus   pamac_vec_if.slave (operand and result handshakes)
//  Revision : 1.0  initial release
// ============================================================================
module pamac_vec
    import pamac_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int A_W       = 16,
    parameter int ACC_W     = 24,
    parameter int MAX_TERMS = 8,
    parameter int POS_W     = 4
) (
    input  wire logic  clk,
    input  wire logic  rst,
    pamac_vec_if.slave bus
);

    localparam int ETC_W = $clog2(MAX_TERMS + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [ETC_W-1:0] r_k;
    logic [ETC_W-1:0] r_n;
    logic [ETC_W-1:0] w_n;
    logic             r_a_signed;
    logic             r_sat_en;
    logic             w_load;
    logic             w_step;

    logic [ETC_W-1:0] w_etc_c [LANES];
    logic [ACC_W-1:0] w_y     [LANES];

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign w_etc_c[i] = ETC_W'(etc_clamp(32'(bus.in_etc[i*ETC_W +: ETC_W]),
                                                 32'(MAX_TERMS)));

            pamac_term_lane #(
                .A_W       (A_W),
                .ACC_W     (ACC_W),
                .MAX_TERMS (MAX_TERMS),
                .POS_W     (POS_W),
                .ETC_W     (ETC_W)
            ) u_lane (
                .clk      (clk),
                .rst      (rst),
                .load     (w_load),
                .step     (w_step),
                .k        (r_k),
                .a        (bus.in_a[i*A_W +: A_W]),
                .t        (bus.in_t[i*ACC_W +: ACC_W]),
                .etc      (w_etc_c[i]),
                .pos      (bus.in_pos[i*MAX_TERMS*POS_W +: MAX_TERMS*POS_W]),
                .neg      (bus.in_neg[i*MAX_TERMS +: MAX_TERMS]),
                .a_signed (r_a_signed),
                .sat_en   (r_sat_en),
                .y        (w_y[i])
            );

            assign bus.out_y[i*ACC_W +: ACC_W] = w_y[i];
        end
    endgenerate

    // Run length is set by the lane with the most (clamped) terms.
    always_comb begin
        w_n = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_etc_c[i] > w_n) begin
                w_n = w_etc_c[i];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_load       = 1'b1;
                    w_state_next = (w_n != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_k == (r_n - ETC_W'(1))) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_k        <= '0;
            r_n        <= '0;
            r_a_signed <= 1'b0;
            r_sat_en   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_k        <= '0;
                r_n        <= w_n;
                r_a_signed <= bus.a_signed;
                r_sat_en   <= bus.sat_en;
            end else if (w_step) begin
                r_k <= r_k + ETC_W'(1);
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire
